// File: rtl/stack_mc_if.sv
// Control-side bundle between the stack CPU controller and its datapath/memory.
// master = controller, slave = datapath.
interface stack_mc_if;
  logic       run;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] adr_sel;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src_sel;
  logic       stk_push;
  logic       stk_pop;
  logic       stk_tos;
  logic       a_ld;
  logic       b_ld;
  logic [1:0] alu_op;
  logic [1:0] stk_din_sel;
  logic       instr_done;
  logic       busy;
  logic       fault;

  modport master (
    input  run, opcode, zero, mem_ready,
    output adr_sel, mem_read, mem_write, ir_write, pc_write, pc_src_sel,
           stk_push, stk_pop, stk_tos, a_ld, b_ld, alu_op, stk_din_sel,
           instr_done, busy, fault
  );

  modport slave (
    output run, opcode, zero, mem_ready,
    input  adr_sel, mem_read, mem_write, ir_write, pc_write, pc_src_sel,
           stk_push, stk_pop, stk_tos, a_ld, b_ld, alu_op, stk_din_sel,
           instr_done, busy, fault
  );
endinterface

// File: rtl/stack_mc_controller.sv
// Multicycle control FSM for the 8-bit stack CPU: fetch, decode, stack ops,
// handshaked memory access with a timeout watchdog that latches a sticky fault.
module stack_mc_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  stack_mc_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_POP_A, S_POP_B, S_ALU_WB, S_MEM_RD,
    S_PUSH_WB, S_POP_TOS, S_MEM_WR, S_JZ_TOS, S_JZ_EVAL, S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fault_q, fault_d;
  logic               mem_wait;
  logic               done;
  state_t             next_instr;

  // Outputs are decoded from the state register plus the same-cycle
  // mem_ready/zero inputs, so a completed access strobes without an extra cycle.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d         = state_q;
    cnt_d           = cnt_q;
    fault_d         = fault_q;
    mem_wait        = 1'b0;
    done            = 1'b0;
    next_instr      = bus.run ? S_FETCH : S_IDLE;
    bus.adr_sel     = 2'd0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_src_sel  = 2'd0;
    bus.stk_push    = 1'b0;
    bus.stk_pop     = 1'b0;
    bus.stk_tos     = 1'b0;
    bus.a_ld        = 1'b0;
    bus.b_ld        = 1'b0;
    bus.alu_op      = 2'd0;
    bus.stk_din_sel = 2'd0;

    unique case (state_q)
      S_IDLE: if (bus.run) state_d = S_FETCH;
      S_FETCH: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = S_DECODE;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_DECODE: begin
        unique case (bus.opcode)
          3'd0, 3'd1, 3'd2, 3'd3: state_d = S_POP_A;
          3'd4:                   state_d = S_MEM_RD;
          3'd5:                   state_d = S_POP_TOS;
          3'd6: begin
            bus.pc_write   = 1'b1;
            bus.pc_src_sel = 2'd1;
            done           = 1'b1;
          end
          default:                state_d = S_JZ_TOS;
        endcase
      end
      S_POP_A: begin
        bus.stk_pop = 1'b1;
        bus.a_ld    = 1'b1;
        state_d     = (bus.opcode == 3'd3) ? S_ALU_WB : S_POP_B;
      end
      S_POP_B: begin
        bus.stk_pop = 1'b1;
        bus.b_ld    = 1'b1;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        bus.alu_op   = bus.opcode[1:0];
        bus.stk_push = 1'b1;
        done         = 1'b1;
      end
      S_MEM_RD: begin
        bus.adr_sel  = 2'd1;
        bus.mem_read = 1'b1;
        if (bus.mem_ready) state_d = S_PUSH_WB;
        else               mem_wait = 1'b1;
      end
      S_PUSH_WB: begin
        bus.stk_din_sel = 2'd1;
        bus.stk_push    = 1'b1;
        done            = 1'b1;
      end
      S_POP_TOS: begin
        bus.stk_pop = 1'b1;
        bus.a_ld    = 1'b1;
        state_d     = S_MEM_WR;
      end
      S_MEM_WR: begin
        bus.adr_sel   = 2'd1;
        bus.mem_write = 1'b1;
        if (bus.mem_ready) done = 1'b1;
        else               mem_wait = 1'b1;
      end
      S_JZ_TOS: begin
        bus.stk_tos = 1'b1;
        bus.a_ld    = 1'b1;
        state_d     = S_JZ_EVAL;
      end
      S_JZ_EVAL: begin
        if (bus.zero) begin
          bus.pc_write   = 1'b1;
          bus.pc_src_sel = 2'd1;
        end
        done = 1'b1;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    if (done) state_d = next_instr;

    // The watchdog fires on the wait cycle that brings the count to the limit.
    if (mem_wait && (MEM_TIMEOUT != 0) && (cnt_q + 1'b1 == TIMEOUT)) begin
      state_d = S_FAULT;
      fault_d = 1'b1;
    end

    if (state_d != state_q) cnt_d = '0;
    else if (mem_wait)      cnt_d = cnt_q + 1'b1;
  end

  assign bus.instr_done = done;
  assign bus.busy       = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign bus.fault      = fault_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_stack_mc_controller.sv
// Directed bench for stack_mc_controller: instruction sequences, memory waits,
// jz both ways, run drop, reset mid-access and the watchdog fault (timeout = 4).
module tb_stack_mc_controller;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  stack_mc_if bus ();

  stack_mc_controller #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {bus.adr_sel, bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write,
                bus.pc_src_sel, bus.stk_push, bus.stk_pop, bus.stk_tos, bus.a_ld,
                bus.b_ld, bus.alu_op, bus.stk_din_sel, bus.instr_done, bus.busy,
                bus.fault};

  function automatic logic [19:0] ov(input int adr, mr, mw, irw, pcw, pcs, push, pop,
                                     tos, ald, bld, alu, dsel, dn, bsy, flt);
    return {2'(adr), 1'(mr), 1'(mw), 1'(irw), 1'(pcw), 2'(pcs), 1'(push), 1'(pop),
            1'(tos), 1'(ald), 1'(bld), 2'(alu), 2'(dsel), 1'(dn), 1'(bsy), 1'(flt)};
  endfunction

  task automatic check(input string tag, input logic [19:0] exp);
    #1;
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [19:0] v_idle, v_fetch, v_fwait, v_dec, v_popa, v_popb, v_memrd, v_pushwb;
  logic [19:0] v_poptos, v_memwr, v_jztos, v_jzt, v_jzf, v_fault;

  initial begin
    v_idle   = '0;
    //            adr mr mw irw pcw pcs push pop tos ald bld alu dsel dn bsy flt
    v_fetch  = ov(0,  1, 0, 1,  1,  0,  0,   0,  0,  0,  0,  0,  0,   0, 1,  0);
    v_fwait  = ov(0,  1, 0, 0,  0,  0,  0,   0,  0,  0,  0,  0,  0,   0, 1,  0);
    v_dec    = ov(0,  0, 0, 0,  0,  0,  0,   0,  0,  0,  0,  0,  0,   0, 1,  0);
    v_popa   = ov(0,  0, 0, 0,  0,  0,  0,   1,  0,  1,  0,  0,  0,   0, 1,  0);
    v_popb   = ov(0,  0, 0, 0,  0,  0,  0,   1,  0,  0,  1,  0,  0,   0, 1,  0);
    v_memrd  = ov(1,  1, 0, 0,  0,  0,  0,   0,  0,  0,  0,  0,  0,   0, 1,  0);
    v_pushwb = ov(0,  0, 0, 0,  0,  0,  1,   0,  0,  0,  0,  0,  1,   1, 1,  0);
    v_poptos = v_popa;
    v_memwr  = ov(1,  0, 1, 0,  0,  0,  0,   0,  0,  0,  0,  0,  0,   0, 1,  0);
    v_jztos  = ov(0,  0, 0, 0,  0,  0,  0,   0,  1,  1,  0,  0,  0,   0, 1,  0);
    v_jzt    = ov(0,  0, 0, 0,  1,  1,  0,   0,  0,  0,  0,  0,  0,   1, 1,  0);
    v_jzf    = ov(0,  0, 0, 0,  0,  0,  0,   0,  0,  0,  0,  0,  0,   1, 1,  0);
    v_fault  = ov(0,  0, 0, 0,  0,  0,  0,   0,  0,  0,  0,  0,  0,   0, 0,  1);

    rst_n = 1'b0;
    bus.run = 1'b0; bus.opcode = 3'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    check("reset", v_idle);
    @(negedge clk);
    rst_n = 1'b1;
    check("idle_after_reset", v_idle);

    // add: 5 cycles
    bus.run = 1'b1; bus.mem_ready = 1'b1; bus.opcode = 3'd0;
    check("idle_run_set", v_idle);
    tick(); check("add_fetch", v_fetch);
    tick(); check("add_decode", v_dec);
    tick(); check("add_pop_a", v_popa);
    tick(); check("add_pop_b", v_popb);
    tick(); check("add_alu_wb", ov(0,0,0,0,0,0,1,0,0,0,0,0,0,1,1,0));

    // push with 3 wait cycles in MEM_RD: 7 cycles
    tick(); bus.opcode = 3'd4; check("push_fetch", v_fetch);
    tick(); bus.mem_ready = 1'b0; check("push_decode", v_dec);
    tick(); check("push_memrd_w1", v_memrd);
    tick(); check("push_memrd_w2", v_memrd);
    tick(); check("push_memrd_w3", v_memrd);
    tick(); bus.mem_ready = 1'b1; check("push_memrd_rdy", v_memrd);
    tick(); check("push_wb", v_pushwb);

    // jz taken
    tick(); bus.opcode = 3'd7; bus.zero = 1'b1; check("jz1_fetch", v_fetch);
    tick(); check("jz1_decode", v_dec);
    tick(); check("jz1_tos", v_jztos);
    tick(); check("jz1_eval_taken", v_jzt);
    // jz not taken
    tick(); bus.zero = 1'b0; check("jz0_fetch", v_fetch);
    tick(); check("jz0_decode", v_dec);
    tick(); check("jz0_tos", v_jztos);
    tick(); check("jz0_eval_not_taken", v_jzf);

    // not: skips POP_B
    tick(); bus.opcode = 3'd3; check("not_fetch", v_fetch);
    tick(); check("not_decode", v_dec);
    tick(); check("not_pop_a", v_popa);
    tick(); check("not_alu_wb", ov(0,0,0,0,0,0,1,0,0,0,0,3,0,1,1,0));

    // jmp: done in DECODE, back in FETCH on cycle 3
    tick(); bus.opcode = 3'd6; check("jmp_fetch", v_fetch);
    tick(); check("jmp_decode", v_jzt);
    tick(); bus.opcode = 3'd1; check("jmp_next_fetch", v_fetch);

    // sub with run dropped during POP_B
    tick(); check("sub_decode", v_dec);
    tick(); check("sub_pop_a", v_popa);
    tick(); bus.run = 1'b0; check("sub_pop_b_run0", v_popb);
    tick(); check("sub_alu_wb", ov(0,0,0,0,0,0,1,0,0,0,0,1,0,1,1,0));
    tick(); check("sub_then_idle", v_idle);
    tick(); check("idle_stays", v_idle);

    // pop, reset asserted during MEM_WR
    bus.run = 1'b1; bus.opcode = 3'd5;
    tick(); check("pop_fetch", v_fetch);
    tick(); check("pop_decode", v_dec);
    tick(); bus.mem_ready = 1'b0; check("pop_tos", v_poptos);
    tick(); check("pop_memwr_wait", v_memwr);
    rst_n = 1'b0;
    check("pop_memwr_reset", v_idle);
    @(negedge clk);
    rst_n = 1'b1;
    bus.opcode = 3'd6;
    check("post_reset_idle", v_idle);

    // fetch waits 3 cycles then completes (below timeout), counter cleared for next fetch
    tick(); check("wd_fetch_w1", v_fwait);
    tick(); check("wd_fetch_w2", v_fwait);
    tick(); check("wd_fetch_w3", v_fwait);
    tick(); bus.mem_ready = 1'b1; check("wd_fetch_rdy", v_fetch);
    tick(); bus.mem_ready = 1'b0; check("wd_jmp_decode", v_jzt);

    // stuck fetch: fault after the 4th wait cycle
    tick(); check("to_fetch_w1", v_fwait);
    tick(); check("to_fetch_w2", v_fwait);
    tick(); check("to_fetch_w3", v_fwait);
    tick(); check("to_fetch_w4", v_fwait);
    tick(); check("to_fault", v_fault);
    tick(); bus.mem_ready = 1'b1; check("fault_sticky", v_fault);
    tick(); check("fault_sticky_ready", v_fault);
    rst_n = 1'b0;
    check("fault_reset", v_idle);
    @(negedge clk);
    rst_n = 1'b1; bus.run = 1'b0;
    check("fault_cleared_idle", v_idle);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stack_mc_controller.md
Name: stack_mc_controller

Overview:
Multicycle control FSM for the stack CPU.
- Sequences fetch, decode, stack pops/pushes, memory access and PC update for one 8-bit instruction at a time.
- Drives the 2-bit select lines of the datapath 4-input muxes (address, PC source, stack data-in) and all load/strobe enables.
- Memory accesses use a ready handshake, guarded by a timeout watchdog.

Parameters:
MEM_TIMEOUT, 255, max cycles a memory access may wait for mem_ready before fault; 0 disables the watchdog.
CNT_W, 8, width of the watchdog counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  1 = execute instructions; sampled at instruction boundaries
opcode  in  3  IR[7:5]: 0 add, 1 sub, 2 and, 3 not, 4 push, 5 pop, 6 jmp, 7 jz
zero  in  1  datapath flag: A register == 0
mem_ready  in  1  memory completes current read/write this cycle
adr_sel  out  2  address mux select: 0 = PC, 1 = IR[4:0]
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  load IR from memory data
pc_write  out  1  load PC
pc_src_sel  out  2  PC mux select: 0 = PC+1, 1 = IR[4:0]
stk_push  out  1  push stack
stk_pop  out  1  pop stack
stk_tos  out  1  read top of stack without pop
a_ld  out  1  load A register from stack output
b_ld  out  1  load B register from stack output
alu_op  out  2  0 add, 1 sub, 2 and, 3 not(A)
stk_din_sel  out  2  stack data-in mux select: 0 = ALU result, 1 = memory data
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
busy  out  1  1 in every state except IDLE and FAULT
fault  out  1  sticky memory-timeout flag

Behaviour:
- Reset (async, rst_n=0): state = IDLE, watchdog counter = 0, fault = 0. All outputs 0 while in reset and in IDLE.
- Outputs not listed for a state are 0.
- "NEXT" means: go to FETCH if run=1, else IDLE. It is evaluated on the cycle instr_done is asserted.
- IDLE: go to FETCH when run=1.
- FETCH: adr_sel=0, mem_read=1.
  - While mem_ready=0, stay in FETCH.
  - When mem_ready=1 (same cycle): ir_write=1, pc_write=1, pc_src_sel=0, then go to DECODE.
- DECODE: branches on opcode.
  - 0-3 -> POP_A.
  - 4 -> MEM_RD.
  - 5 -> POP_TOS.
  - 7 -> JZ_TOS.
  - 6: pc_write=1, pc_src_sel=1, instr_done=1, then NEXT.
- POP_A: stk_pop=1, a_ld=1. Go to ALU_WB if opcode=3, else POP_B.
- POP_B: stk_pop=1, b_ld=1, then ALU_WB.
- ALU_WB: alu_op=opcode[1:0], stk_din_sel=0, stk_push=1, instr_done=1, then NEXT.
- MEM_RD: adr_sel=1, mem_read=1. Wait for mem_ready, then PUSH_WB.
- PUSH_WB: stk_din_sel=1, stk_push=1, instr_done=1, then NEXT.
- POP_TOS: stk_pop=1, a_ld=1, then MEM_WR.
- MEM_WR: adr_sel=1, mem_write=1. Wait for mem_ready; on the mem_ready cycle instr_done=1, then NEXT.
- JZ_TOS: stk_tos=1, a_ld=1, then JZ_EVAL.
- JZ_EVAL: if zero=1, pc_write=1 and pc_src_sel=1. instr_done=1, then NEXT.
- Latency with mem_ready held at 1:
  - add/sub/and: 5 cycles.
  - not, push, pop, jz: 4 cycles.
  - jmp: 2 cycles.
  - Each wait cycle on mem_ready adds 1.
- Watchdog:
  - Counter clears on entry to FETCH, MEM_RD or MEM_WR.
  - It increments on each cycle in those states with mem_ready=0.
  - When it reaches MEM_TIMEOUT and mem_ready=0: fault=1, state = FAULT, all outputs 0 except fault.
  - FAULT is exited only by reset.
  - mem_ready=1 on the same cycle the count reaches MEM_TIMEOUT wins: no fault.
- run deasserted mid-instruction: the instruction completes, then the FSM goes to IDLE.
- Undefined state encodings go to IDLE.
- Reset asserted mid-instruction: immediate return to IDLE, no partial strobes after rst_n falls.
- Never asserted together: mem_read with mem_write; stk_push with stk_pop.

Test Plan:
- Reset, run=1, mem_ready=1, opcode=0 -> FETCH, DECODE, POP_A, POP_B, ALU_WB. In ALU_WB alu_op=0, stk_push=1, instr_done=1. 5 cycles total.
- opcode=4 with mem_ready low 3 cycles in MEM_RD -> adr_sel=1, mem_read held 4 cycles. Then PUSH_WB with stk_din_sel=1. Instruction takes 7 cycles.
- opcode=7, zero=1, then repeat with zero=0 -> pc_write=1 and pc_src_sel=1 in JZ_EVAL only when zero=1. instr_done asserts in both cases.
- opcode=6 -> pc_write=1, pc_src_sel=1, instr_done=1 in DECODE. Back in FETCH on cycle 3.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> fault=1 after the 4th wait cycle. All other outputs 0 until rst_n pulse.
- run dropped during POP_B; separately rst_n pulsed during MEM_WR -> first completes ALU_WB then goes to IDLE with busy=0; second gives immediate IDLE with mem_write=0.
